// File: rtl/aoc3_line_sequencer_if.sv
// Byte-stream handshake between the ASCII source and the line sequencer.
interface aoc3_line_sequencer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/aoc3_line_sequencer.sv
// ASCII byte stream -> digit strobes plus per-line flush/reset sequencing
// for the day-3 joltage selector. Blocks the source while a line flushes.
module aoc3_line_sequencer #(
  parameter int LINE_LENGTH  = 100,
  parameter int FLUSH_CYCLES = 13,
  parameter int CNT_W        = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  aoc3_line_sequencer_if.slave  bus,
  input  logic                  eof_in,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_in_valid,
  output logic                  newline,
  output logic                  line_reset,
  output logic                  line_done,
  output logic                  line_err,
  output logic [CNT_W-1:0]      lines_count,
  output logic                  idle
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {ST_STREAM, ST_FLUSH, ST_RST, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [FW-1:0]         flush_q;
  logic [CNT_W-1:0]      dcnt_q;
  logic [CNT_W-1:0]      lines_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  dv_q;
  logic                  err_q;

  logic accept, is_digit, is_nl, is_cr, flush_entry;

  assign accept   = bus.byte_valid & bus.byte_ready;
  assign is_digit = (bus.byte_in >= 8'h30) && (bus.byte_in <= 8'h39);
  assign is_nl    = (bus.byte_in == 8'h0A);
  assign is_cr    = (bus.byte_in == 8'h0D);
  // Line-length check happens on the edge that enters FLUSH.
  assign flush_entry = (state_q != ST_FLUSH) && (state_d == ST_FLUSH);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_STREAM;
    else        state_q <= state_d;
  end

  // Next-state: eof only matters in STREAM; byte_ready is low while eof is
  // high, so an accepted '\n' and eof are never seen together here.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STREAM: begin
        if (eof_in)
          state_d = (dcnt_q != '0) ? ST_FLUSH : ST_DONE;
        else if (accept && is_nl && (dcnt_q != '0))
          state_d = ST_FLUSH;
      end
      ST_FLUSH: if (flush_q == '0) state_d = ST_RST;
      ST_RST:   state_d = ST_STREAM;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_STREAM;
    endcase
  end

  // Outputs decoded from state; reset gating keeps byte_ready low in reset.
  always_comb begin
    bus.byte_ready = reset & (state_q == ST_STREAM) & ~eof_in;
    newline        = (state_q == ST_FLUSH) | (state_q == ST_RST);
    line_reset     = (state_q == ST_RST);
    line_done      = (state_q == ST_RST);
    idle           = (state_q == ST_DONE);
  end

  // Digit strobe and held digit value ('0'..'9' low nibble is the value).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dv_q   <= 1'b0;
      data_q <= '0;
    end else begin
      dv_q <= accept & is_digit;
      if (accept && is_digit) data_q <= DATA_WIDTH'(bus.byte_in[3:0]);
    end
  end

  // Saturating digit counter, cleared in the RST cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                dcnt_q <= '0;
    else if (state_q == ST_RST)                dcnt_q <= '0;
    else if (accept && is_digit && ~&dcnt_q)   dcnt_q <= dcnt_q + 1'b1;
  end

  // Flush down-counter: loaded on entry so FLUSH lasts FLUSH_CYCLES cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                  flush_q <= '0;
    else if (flush_entry)                        flush_q <= FW'(FLUSH_CYCLES - 1);
    else if (state_q == ST_FLUSH && flush_q != '0) flush_q <= flush_q - 1'b1;
  end

  // Sticky error: bad character or wrong digit count at flush entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else if ((accept && !is_digit && !is_nl && !is_cr) ||
             (flush_entry && dcnt_q != CNT_W'(LINE_LENGTH)))
      err_q <= 1'b1;
  end

  // Saturating completed-line counter, bumped at the end of RST.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                            lines_q <= '0;
    else if (state_q == ST_RST && ~&lines_q) lines_q <= lines_q + 1'b1;
  end

  assign data_in       = data_q;
  assign data_in_valid = dv_q;
  assign line_err      = err_q;
  assign lines_count   = lines_q;

endmodule

// File: doc/aoc3_line_sequencer.md
Name: aoc3_line_sequencer

Overview:
- Upstream stage of the day-3 joltage selector `top`.
- Converts a raw ASCII byte stream (one input-file byte per transfer) into the digit strobes and end-of-line sequencing that `top` consumes: `data_in`/`data_in_valid` per digit, `newline` flush window, one-cycle `line_reset` pulse.
- Drives `top`'s `data_in`, `data_in_valid` and `newline` ports directly. Its `line_reset` is combined into `top`'s reset by the integration level.
- Back-pressures the byte source while a line is being flushed.
- Checks line length and tracks line count.

Parameters:
- LINE_LENGTH, 100, expected digits per line; must match `top.line_length`.
- FLUSH_CYCLES, 13, cycles `newline` is held before the reset pulse (`top` stack depth 12, plus 1).
- CNT_W, 16, width of the line and digit counters.

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- byte_in  in  8  ASCII byte from file/host
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  block accepts byte this cycle
- eof_in  in  1  level: stream exhausted, no further bytes
- data_in  out  `DATA_WIDTH  digit value 0..9, zero-extended
- data_in_valid  out  1  one-cycle strobe per digit
- newline  out  1  end-of-line flush window to top
- line_reset  out  1  one-cycle clear pulse for top after flush
- line_done  out  1  one-cycle pulse in the last line_reset cycle
- line_err  out  1  sticky: bad char or wrong line length seen
- lines_count  out  CNT_W  lines completed (saturating)
- idle  out  1  all input consumed, eof seen, no flush pending

Behaviour:
Reset (reset=0, async):
- All outputs 0.
- FSM in STREAM; counters 0.

Handshake:
- Transfer occurs when byte_valid & byte_ready.
- byte_ready = (state==STREAM) & ~eof_in, combinational from state.
- No skid buffer; the source must hold byte_in until accepted.

FSM states:
- STREAM
  - Digit '0'..'9' accepted in cycle N: data_in = byte-48 and data_in_valid=1 in cycle N+1 only. digit_count++ (saturating).
  - '\r' (13): dropped silently.
  - '\n' (10) with digit_count>0: go to FLUSH at N+1.
  - '\n' with digit_count==0: dropped; no flush, count unchanged.
  - Any other byte: dropped; line_err set.
  - eof_in=1 with digit_count>0: go to FLUSH (synthetic final newline).
  - eof_in=1 with digit_count==0: go to DONE.
- FLUSH
  - newline=1, data_in_valid=0 for exactly FLUSH_CYCLES cycles (down-counter), then go to RST.
  - On entry: if digit_count != LINE_LENGTH, set line_err.
- RST
  - One cycle: newline=1, line_reset=1, line_done=1.
  - lines_count++ (saturate at all-ones); digit_count cleared.
  - Next state STREAM. newline and line_reset are 0 in the following cycle.
- DONE
  - idle=1, byte_ready=0; terminal until reset.

Latency and throughput:
- Digit byte to data_in_valid: 1 cycle. Streaming throughput: 1 byte/cycle.
- Per-line overhead: FLUSH_CYCLES+1 cycles of byte_ready=0, counted from the cycle after '\n' is accepted.

Other rules:
- data_in holds its last value when data_in_valid=0.
- line_err is cleared only by reset.
- A reset asserted mid-FLUSH or mid-RST aborts immediately: newline and line_reset drop asynchronously, FSM returns to STREAM with counters 0.
- eof_in asserted in the same cycle as an accepted '\n': the newline takes precedence (FLUSH). eof_in is then evaluated in STREAM after RST, giving DONE.
- digit_count saturates and does not wrap. A line with more than 2^CNT_W digits still flags line_err.

Test Plan:
- LINE_LENGTH=15, bytes "987654321111111\n" back-to-back:
  - 15 data_in_valid pulses, values 9,8,…,1,1,1,1,1,1,1.
  - newline high 13 cycles, then line_reset and line_done for 1 cycle.
  - lines_count=1, line_err=0, byte_ready low for 14 cycles.
- Same line, no trailing '\n', then eof_in=1:
  - Synthetic flush: 13 newline cycles plus 1 line_reset.
  - lines_count=1, then idle=1 and byte_ready=0.
- "12\r\n\n34" with LINE_LENGTH=2, then eof:
  - '\r' ignored; the empty line produces no flush.
  - Two flushes, lines_count=2, line_err=0.
  - Digit pulses 1,2,3,4.
- "9a8\n" with LINE_LENGTH=2:
  - Digits 9,8 emitted; 'a' dropped; line_err=1.
  - Flush still occurs; line_err stays 1 across the next valid line.
- LINE_LENGTH=100, 99-digit line: line_err=1 at FLUSH entry, lines_count=1.
- reset=0 asserted on the 5th FLUSH cycle:
  - newline, line_reset and lines_count are 0 in the same cycle (async).
  - After release, byte_ready=1 and a fresh line processes normally.
